// File: rtl/sel8_rr_sequencer.sv
// sel8_rr_sequencer: round-robin select generator for the 3-bit S input of an
// 8:1 mux stage. Eight request lines are arbitrated round-robin, and the winning
// index is presented downstream with a valid/ready handshake. An optional
// programmable idle gap can be inserted after each accepted grant.
//
// Optional feature macro: SEL8_GRANT_COUNT_EN
//   defined   -> o_grant_cnt is a saturating count of accepted grants
//   undefined -> o_grant_cnt is tied to zero and no counter flops are built
module sel8_rr_sequencer #(
  parameter int GAP_CYCLES = 0,  // idle cycles after each accepted grant (0 = back-to-back)
  parameter int GAP_W      = 4   // gap counter width; GAP_CYCLES <= 2**GAP_W-1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic       i_ready,
  output logic [2:0] o_sel,
  output logic       o_valid,
  output logic [7:0] o_gnt,
  output logic [7:0] o_grant_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [2:0]       r_last;
  logic             r_valid;
  logic [GAP_W-1:0] r_gap_cnt;

  logic             w_req_any;
  logic             w_hs;
  logic [2:0]       w_pick_last;
  logic [2:0]       w_pick_sel;

  // Round-robin search: first set bit starting at base+1, wrapping 7->0.
  // The base itself is checked last, so a lone requester is re-granted.
  // Walking k downwards lets the nearest hit overwrite farther ones.
  function automatic logic [2:0] f_pick(input logic [7:0] req, input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] res;
    res = base;
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  assign w_req_any   = |i_req;
  // valid is only ever high in GRANT, so this is the handshake.
  assign w_hs        = r_valid && i_ready;
  // Pick when resuming from IDLE/GAP: last grant already recorded in r_last.
  assign w_pick_last = f_pick(i_req, r_last);
  // Pick on a back-to-back handshake: the grant being accepted becomes the new last.
  assign w_pick_sel  = f_pick(i_req, r_sel);

  // Sequencer FSM: sel/valid are registered so there is no comb path req->valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= 3'd0;
      r_last    <= 3'd7;
      r_valid   <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_sel   <= w_pick_last;
            r_valid <= 1'b1;
            r_state <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          // sel stays frozen until the consumer accepts, whatever req does.
          if (w_hs) begin
            r_last <= r_sel;
            if (GAP_CYCLES == 0) begin
              if (w_req_any) begin
                r_sel <= w_pick_sel;
              end else begin
                r_valid <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_valid   <= 1'b0;
              r_gap_cnt <= GAP_LOAD;
              r_state   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          // Final gap cycle arbitrates exactly like IDLE so the total idle
          // time is GAP_CYCLES cycles.
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            if (w_req_any) begin
              r_sel   <= w_pick_last;
              r_valid <= 1'b1;
              r_state <= ST_GRANT;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_LAST;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_valid = r_valid;

  // One-hot grant, forced to zero whenever there is no live grant.
  for (genvar gi = 0; gi < 8; gi++) begin : g_gnt
    assign o_gnt[gi] = r_valid && (r_sel == 3'(gi));
  end

`ifdef SEL8_GRANT_COUNT_EN
  logic [7:0] r_grant_cnt;

  // Saturating count of accepted grants; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant_cnt <= 8'd0;
    end else if (w_hs && (r_grant_cnt != 8'hFF)) begin
      r_grant_cnt <= r_grant_cnt + 8'd1;
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`else
  assign o_grant_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sel8_rr_sequencer.sv
// Directed bench for sel8_rr_sequencer: one back-to-back instance (GAP_CYCLES=0)
// and one gapped instance (GAP_CYCLES=3), sharing clock and reset.
module tb_sel8_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req0, req3;
  logic       rdy0, rdy3;
  logic [2:0] sel0, sel3;
  logic       vld0, vld3;
  logic [7:0] gnt0, gnt3;
  logic [7:0] cnt0, cnt3;

  int total = 0;
  int bad   = 0;

  sel8_rr_sequencer #(.GAP_CYCLES(0), .GAP_W(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_ready(rdy0),
    .o_sel(sel0), .o_valid(vld0), .o_gnt(gnt0), .o_grant_cnt(cnt0)
  );

  sel8_rr_sequencer #(.GAP_CYCLES(3), .GAP_W(4)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_ready(rdy3),
    .o_sel(sel3), .o_valid(vld3), .o_gnt(gnt3), .o_grant_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs written after this are
  // stable well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0  = 8'hFF; rdy0 = 1'b0;
    req3  = 8'h00; rdy3 = 1'b0;
    step(); step();

    // Reset state with all requests pending
    chk("rst_sel",   32'(sel0), 32'd0);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_gnt",   32'(gnt0), 32'h00);
    chk("rst_cnt",   32'(cnt0), 32'd0);
    chk("rst_valid3",32'(vld3), 32'd0);

    // Release: first grant one edge later, search from last=7 -> 0
    rst_n = 1'b1;
    step();
    chk("rel_sel",   32'(sel0), 32'd0);
    chk("rel_valid", 32'(vld0), 32'd1);
    chk("rel_gnt",   32'(gnt0), 32'h01);

    // Round-robin order with ready held high
    rdy0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("rr_sel",   32'(sel0), 32'(k % 8));
      chk("rr_valid", 32'(vld0), 32'd1);
    end

    // Backpressure: handshake on sel=0 picks 2 out of 8'h24, then hold
    req0 = 8'h24;
    step();
    chk("bp_first", 32'(sel0), 32'd2);
    rdy0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_sel", 32'(sel0), 32'd2);
      chk("bp_gnt", 32'(gnt0), 32'h04);
    end
    rdy0 = 1'b1;
    step();
    chk("bp_next", 32'(sel0), 32'd5);
    step();
    chk("bp_wrap", 32'(sel0), 32'd2);

    // Requests drop while stalled: grant stays frozen
    req0 = 8'h00; rdy0 = 1'b0;
    step(); step();
    chk("drop_sel",   32'(sel0), 32'd2);
    chk("drop_valid", 32'(vld0), 32'd1);

    // Accept with no requests -> idle; ready while idle is ignored
    rdy0 = 1'b1;
    step();
    chk("idle_valid", 32'(vld0), 32'd0);
    chk("idle_gnt",   32'(gnt0), 32'h00);
    step();
    chk("idle_hold",  32'(vld0), 32'd0);

    // Single requester is re-granted on every handshake
    req0 = 8'h08;
    step();
    chk("one_sel",   32'(sel0), 32'd3);
    chk("one_valid", 32'(vld0), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("one_again", 32'(sel0), 32'd3);
      chk("one_gnt",   32'(gnt0), 32'h08);
    end

    // Mid-operation reset while granting channel 6
    req0 = 8'h40;
    step();
    chk("mr_pre", 32'(sel0), 32'd6);
    rdy0 = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(vld0), 32'd0);
    chk("mr_sel",   32'(sel0), 32'd0);
    chk("mr_gnt",   32'(gnt0), 32'h00);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mr_resel",  32'(sel0), 32'd6);
    chk("mr_revalid",32'(vld0), 32'd1);

    // Gapped instance: valid 1,0,0,0,1,... with sel=0 on each grant
    req3 = 8'h01; rdy3 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk("gap_valid", 32'(vld3), 32'((k % 4) == 0));
      if ((k % 4) == 0) chk("gap_sel", 32'(sel3), 32'd0);
    end

    // Grant counter: saturates at 255 when built in, else always zero
    rst_n = 1'b0; req0 = 8'hFF; rdy0 = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("cnt_first", 32'(cnt0), 32'd0);
    repeat (5) step();
`ifdef SEL8_GRANT_COUNT_EN
    chk("cnt_five", 32'(cnt0), 32'd5);
`else
    chk("cnt_five", 32'(cnt0), 32'd0);
`endif
    repeat (300) step();
`ifdef SEL8_GRANT_COUNT_EN
    chk("cnt_sat", 32'(cnt0), 32'd255);
`else
    chk("cnt_sat", 32'(cnt0), 32'd0);
`endif
    chk("cnt_valid", 32'(vld0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
